// File: rtl/wave_pkg.sv
// Shared encodings and width defaults for the waveform parameter scheduler.
// The SWEEP state exists only when WAVE_SWEEP_EN is defined.
package wave_pkg;

    localparam int ACC_W_DEF  = 28;
    localparam int FREQ_W_DEF = 20;
    localparam int PWM_W_DEF  = 7;
    localparam int DWELL_W    = 16;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'b00,
        WAVE_TRI  = 2'b01,
        WAVE_SQR  = 2'b10,
        WAVE_PWM  = 2'b11
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
`ifdef WAVE_SWEEP_EN
        ,
        ST_SWEEP = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/wave_param_sched_if.sv
// Parameter-set offer channel: valid/ready handshake carrying one parameter set.
interface wave_param_sched_if #(
    parameter int FREQ_W = 20,
    parameter int PWM_W  = 7
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_wave;
    logic [FREQ_W-1:0] cfg_freq;
    logic [PWM_W-1:0]  cfg_pwm;
    logic              cfg_immediate;

    modport master (
        output cfg_valid, cfg_wave, cfg_freq, cfg_pwm, cfg_immediate,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_wave, cfg_freq, cfg_pwm, cfg_immediate,
        output cfg_ready
    );
endinterface

// File: rtl/wave_wrap_det.sv
// Phase-wrap detector: strobes for the cycle in which the accumulator MSB
// is seen falling from 1 to 0.
module wave_wrap_det (
    input  logic clk_100m,
    input  logic rst,
    input  logic phase_msb,
    output logic wrap
);
    logic msb_q, msb_d;

    always_comb begin
        msb_d = phase_msb;
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) msb_q <= 1'b0;
        else     msb_q <= msb_d;
    end

    assign wrap = msb_q & ~phase_msb;
endmodule

// File: rtl/wave_param_sched.sv
// Shadow/active parameter scheduler for the wave generator: new sets are held
// until a phase wrap (or applied at once). WAVE_SWEEP_EN adds a linear freq sweep.
module wave_param_sched
    import wave_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int PWM_W  = PWM_W_DEF
) (
    input  logic                clk_100m,
    input  logic                rst,
    input  logic                enable,
    wave_param_sched_if.slave   cfg,
    input  logic                phase_msb,
    output logic [ACC_W-1:0]    freq_inc,
    output logic [1:0]          wave_sel,
    output logic [PWM_W-1:0]    pwm_duty,
    output logic                acc_clear,
    output logic                update_pulse
`ifdef WAVE_SWEEP_EN
    ,
    input  logic                sweep_go,
    input  logic [FREQ_W-1:0]   sweep_step,
    input  logic [FREQ_W-1:0]   sweep_end,
    input  logic [DWELL_W-1:0]  sweep_dwell,
    output logic                sweep_busy
`endif
);
    state_e            state_q, state_d;
    logic [1:0]        sh_wave_q, sh_wave_d, act_wave_q, act_wave_d;
    logic [FREQ_W-1:0] sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
    logic [PWM_W-1:0]  sh_pwm_q, sh_pwm_d, act_pwm_q, act_pwm_d;
    logic              update_q, update_d;
    logic              acc_clear_q, acc_clear_d;
    logic              wrap;
    logic              xfer;

`ifdef WAVE_SWEEP_EN
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [FREQ_W:0]    sweep_sum;
    logic [FREQ_W-1:0]  sweep_next;

    // One extra bit so the add cannot wrap before the saturation compare.
    assign sweep_sum  = {1'b0, act_freq_q} + {1'b0, sweep_step};
    assign sweep_next = (sweep_sum >= {1'b0, sweep_end}) ? sweep_end : sweep_sum[FREQ_W-1:0];
    assign sweep_busy = (state_q == ST_SWEEP);
`endif

    wave_wrap_det u_wrap (
        .clk_100m  (clk_100m),
        .rst       (rst),
        .phase_msb (phase_msb),
        .wrap      (wrap)
    );

    assign cfg.cfg_ready = (state_q == ST_IDLE);
    assign xfer          = cfg.cfg_valid & cfg.cfg_ready;

    always_comb begin
        state_d     = state_q;
        sh_wave_d   = sh_wave_q;
        sh_freq_d   = sh_freq_q;
        sh_pwm_d    = sh_pwm_q;
        act_wave_d  = act_wave_q;
        act_freq_d  = act_freq_q;
        act_pwm_d   = act_pwm_q;
        update_d    = 1'b0;
        acc_clear_d = ~enable;
`ifdef WAVE_SWEEP_EN
        dwell_d     = dwell_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A wrap coinciding with the transfer is deliberately not looked at here,
                // so a wrap-gated set always waits for the following wrap.
                if (xfer) begin
                    sh_wave_d = cfg.cfg_wave;
                    sh_freq_d = cfg.cfg_freq;
                    sh_pwm_d  = cfg.cfg_pwm;
                    if (cfg.cfg_immediate || !enable || act_freq_q == '0)
                        state_d = ST_APPLY;
                    else
                        state_d = ST_PEND;
                end
`ifdef WAVE_SWEEP_EN
                else if (sweep_go) begin
                    state_d = ST_SWEEP;
                    dwell_d = '0;
                end
`endif
            end
            ST_PEND: begin
                if (wrap || !enable) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                act_wave_d = sh_wave_q;
                act_freq_d = sh_freq_q;
                act_pwm_d  = sh_pwm_q;
                update_d   = 1'b1;
                state_d    = ST_IDLE;
            end
`ifdef WAVE_SWEEP_EN
            ST_SWEEP: begin
                if (act_freq_q == sweep_end) begin
                    state_d = ST_IDLE;
                end else if (dwell_q == sweep_dwell) begin
                    dwell_d    = '0;
                    act_freq_d = sweep_next;
                    update_d   = 1'b1;
                    if (sweep_next == sweep_end) state_d = ST_IDLE;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sh_wave_q   <= WAVE_SINE;
            sh_freq_q   <= '0;
            sh_pwm_q    <= '0;
            act_wave_q  <= WAVE_SINE;
            act_freq_q  <= '0;
            act_pwm_q   <= '0;
            update_q    <= 1'b0;
            acc_clear_q <= 1'b1;
`ifdef WAVE_SWEEP_EN
            dwell_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sh_wave_q   <= sh_wave_d;
            sh_freq_q   <= sh_freq_d;
            sh_pwm_q    <= sh_pwm_d;
            act_wave_q  <= act_wave_d;
            act_freq_q  <= act_freq_d;
            act_pwm_q   <= act_pwm_d;
            update_q    <= update_d;
            acc_clear_q <= acc_clear_d;
`ifdef WAVE_SWEEP_EN
            dwell_q     <= dwell_d;
`endif
        end
    end

    assign freq_inc     = {{(ACC_W-FREQ_W){1'b0}}, act_freq_q};
    assign wave_sel     = act_wave_q;
    assign pwm_duty     = act_pwm_q;
    assign acc_clear    = acc_clear_q;
    assign update_pulse = update_q;
endmodule

// File: tb/tb_wave_param_sched.sv
// Directed bench for wave_param_sched: immediate, wrap-gated, zero-freq escape,
// enable drop, reset while pending, and the sweep when WAVE_SWEEP_EN is defined.
module tb_wave_param_sched;
    localparam int ACC_W  = 28;
    localparam int FREQ_W = 20;
    localparam int PWM_W  = 7;

    logic              clk_100m = 1'b0;
    logic              rst;
    logic              enable;
    logic              phase_msb;
    logic [ACC_W-1:0]  freq_inc;
    logic [1:0]        wave_sel;
    logic [PWM_W-1:0]  pwm_duty;
    logic              acc_clear;
    logic              update_pulse;
`ifdef WAVE_SWEEP_EN
    logic              sweep_go;
    logic [FREQ_W-1:0] sweep_step;
    logic [FREQ_W-1:0] sweep_end;
    logic [15:0]       sweep_dwell;
    logic              sweep_busy;
    int                n_pulse;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wave_param_sched_if #(.FREQ_W(FREQ_W), .PWM_W(PWM_W)) cfg_if ();

    wave_param_sched #(.ACC_W(ACC_W), .FREQ_W(FREQ_W), .PWM_W(PWM_W)) dut (
        .clk_100m     (clk_100m),
        .rst          (rst),
        .enable       (enable),
        .cfg          (cfg_if),
        .phase_msb    (phase_msb),
        .freq_inc     (freq_inc),
        .wave_sel     (wave_sel),
        .pwm_duty     (pwm_duty),
        .acc_clear    (acc_clear),
        .update_pulse (update_pulse)
`ifdef WAVE_SWEEP_EN
        ,
        .sweep_go     (sweep_go),
        .sweep_step   (sweep_step),
        .sweep_end    (sweep_end),
        .sweep_dwell  (sweep_dwell),
        .sweep_busy   (sweep_busy)
`endif
    );

    always #5 clk_100m = ~clk_100m;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    // Offer a set for exactly one cycle; the block is expected to be idle.
    task automatic offer(input logic [19:0] f, input logic [1:0] w, input logic [6:0] p, input logic imm);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_freq      = f;
        cfg_if.cfg_wave      = w;
        cfg_if.cfg_pwm       = p;
        cfg_if.cfg_immediate = imm;
        tick();
        cfg_if.cfg_valid     = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        enable               = 1'b1;
        phase_msb            = 1'b0;
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_freq      = '0;
        cfg_if.cfg_wave      = '0;
        cfg_if.cfg_pwm       = '0;
        cfg_if.cfg_immediate = 1'b0;
`ifdef WAVE_SWEEP_EN
        sweep_go    = 1'b0;
        sweep_step  = '0;
        sweep_end   = '0;
        sweep_dwell = '0;
`endif
        tick(); tick();
        chk("rst_freq",  freq_inc, 32'h0);
        chk("rst_wave",  wave_sel, 32'h0);
        chk("rst_pwm",   pwm_duty, 32'h0);
        chk("rst_upd",   update_pulse, 32'h0);
        chk("rst_clr",   acc_clear, 32'h1);
        chk("rst_rdy",   cfg_if.cfg_ready, 32'h1);
        rst = 1'b0;
        tick();
        chk("clr_follow_en", acc_clear, 32'h0);

        // Immediate apply: visible two cycles after the transfer cycle
        offer(20'h00400, 2'b01, 7'h15, 1'b1);
        chk("imm_busy_rdy", cfg_if.cfg_ready, 32'h0);
        chk("imm_not_yet",  freq_inc, 32'h0);
        chk("imm_no_upd",   update_pulse, 32'h0);
        tick();
        chk("imm_freq", freq_inc, 32'h0000400);
        chk("imm_wave", wave_sel, 32'h1);
        chk("imm_pwm",  pwm_duty, 32'h15);
        chk("imm_upd",  update_pulse, 32'h1);
        chk("imm_rdy",  cfg_if.cfg_ready, 32'h1);
        tick();
        chk("imm_upd_1cyc", update_pulse, 32'h0);

        // Wrap-gated; the wrap coinciding with the transfer must be ignored
        offer(20'h00100, 2'b10, 7'h20, 1'b1);
        tick(); tick();
        chk("setup_freq", freq_inc, 32'h100);
        phase_msb = 1'b1;
        tick();
        phase_msb = 1'b0;
        offer(20'h00200, 2'b11, 7'h7f, 1'b0);
        chk("pend_rdy",  cfg_if.cfg_ready, 32'h0);
        chk("pend_hold", freq_inc, 32'h100);
        tick();
        chk("pend_coinc_wrap_ignored", cfg_if.cfg_ready, 32'h0);
        phase_msb = 1'b1;
        tick(); tick();
        chk("pend_msb_hi_hold", freq_inc, 32'h100);
        chk("pend_msb_hi_rdy",  cfg_if.cfg_ready, 32'h0);
        phase_msb = 1'b0;
        tick();
        chk("wrap_apply_cycle", freq_inc, 32'h100);
        chk("wrap_apply_noupd", update_pulse, 32'h0);
        tick();
        chk("wrap_freq", freq_inc, 32'h200);
        chk("wrap_wave", wave_sel, 32'h3);
        chk("wrap_pwm",  pwm_duty, 32'h7f);
        chk("wrap_upd",  update_pulse, 32'h1);
        tick();

        // Zero-freq escape: no wrap will ever come, so apply at once
        offer(20'h00000, 2'b00, 7'h00, 1'b1);
        tick(); tick();
        chk("zero_setup", freq_inc, 32'h0);
        offer(20'h00333, 2'b01, 7'h01, 1'b0);
        tick();
        chk("zero_escape_freq", freq_inc, 32'h333);
        chk("zero_escape_upd",  update_pulse, 32'h1);
        tick();

        // Enable drop while pending
        offer(20'h000aa, 2'b01, 7'h02, 1'b0);
        tick();
        chk("en_pend_hold", freq_inc, 32'h333);
        chk("en_pend_rdy",  cfg_if.cfg_ready, 32'h0);
        enable = 1'b0;
        tick();
        chk("en_drop_clr",  acc_clear, 32'h1);
        chk("en_drop_hold", freq_inc, 32'h333);
        tick();
        chk("en_drop_freq", freq_inc, 32'haa);
        chk("en_drop_upd",  update_pulse, 32'h1);
        enable = 1'b1;
        tick();
        chk("en_rise_clr", acc_clear, 32'h0);

        // Reset while pending discards the shadow set
        offer(20'h00123, 2'b10, 7'h33, 1'b0);
        tick();
        chk("rstp_pend_rdy", cfg_if.cfg_ready, 32'h0);
        rst = 1'b1;
        #1;
        chk("rstp_freq", freq_inc, 32'h0);
        chk("rstp_wave", wave_sel, 32'h0);
        chk("rstp_clr",  acc_clear, 32'h1);
        #1;
        rst = 1'b0;
        tick();
        chk("rstp_rdy",     cfg_if.cfg_ready, 32'h1);
        chk("rstp_clr_rel", acc_clear, 32'h0);
        phase_msb = 1'b1;
        tick();
        phase_msb = 1'b0;
        tick(); tick();
        chk("rstp_lost_freq", freq_inc, 32'h0);
        chk("rstp_lost_upd",  update_pulse, 32'h0);

`ifdef WAVE_SWEEP_EN
        offer(20'h00010, 2'b00, 7'h00, 1'b1);
        tick(); tick();
        chk("sw_start", freq_inc, 32'h10);
        sweep_step  = 20'h10;
        sweep_end   = 20'h40;
        sweep_dwell = 16'd3;
        sweep_go    = 1'b1;
        tick();
        sweep_go    = 1'b0;
        chk("sw_busy", sweep_busy, 32'h1);
        chk("sw_rdy",  cfg_if.cfg_ready, 32'h0);
        n_pulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (update_pulse) n_pulse++;
            if (i == 2)  chk("sw_dwell_hold", freq_inc, 32'h10);
            if (i == 3)  chk("sw_step1", freq_inc, 32'h20);
            if (i == 7)  chk("sw_step2", freq_inc, 32'h30);
            if (i == 10) chk("sw_busy_mid", sweep_busy, 32'h1);
            if (i == 11) chk("sw_step3", freq_inc, 32'h40);
            if (i == 11) chk("sw_done", sweep_busy, 32'h0);
        end
        chk("sw_pulses", n_pulse, 32'd3);
        chk("sw_final",  freq_inc, 32'h40);
        chk("sw_rdy_end", cfg_if.cfg_ready, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
